// File: rtl/hamming_rx_serial_pkg.sv
// Shared definitions for the serial Hamming(7,4) receiver: FSM state
// encodings, codeword bit positions and the parity helper used by the
// syndrome calculator.
package hamming_rx_serial_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } rx_state_e;

    // Codeword bit positions (position 1..7 maps to m[0]..m[6]).
    localparam int unsigned P1 = 0;
    localparam int unsigned P2 = 1;
    localparam int unsigned D0 = 2;
    localparam int unsigned P4 = 3;
    localparam int unsigned D1 = 4;
    localparam int unsigned D2 = 5;
    localparam int unsigned D3 = 6;

    // Even parity over four codeword bits; one syndrome bit per call.
    function automatic logic parity4(input logic a, input logic b,
                                     input logic c, input logic d);
        return a ^ b ^ c ^ d;
    endfunction

endpackage

// File: rtl/hamming_rx_serial_if.sv
// Line and result bundle of the serial Hamming receiver. The master side
// drives the serial line and observes the decoded results; the slave side
// is the receiver itself.
interface hamming_rx_serial_if;
    logic       rx;
    logic [3:0] d_out;
    logic       valid;
    logic       corr;
    logic       frame_err;

    modport master (
        output rx,
        input  d_out,
        input  valid,
        input  corr,
        input  frame_err
    );

    modport slave (
        input  rx,
        output d_out,
        output valid,
        output corr,
        output frame_err
    );
endinterface

// File: rtl/hamming_rx_serial_syndrome.sv
// Combinational Hamming(7,4) syndrome calculator and single-error corrector.
// Any non-zero syndrome names the (1-based) position of the flipped bit, so
// double errors are silently miscorrected, which is inherent to the code.
module hamming_syndrome_7_4
    import hamming_rx_serial_pkg::*;
(
    input  logic [6:0] m,
    output logic [2:0] syndrome,
    output logic [3:0] d_corr,
    output logic       corr
);

    logic [6:0] m_fix_s;

    // Compute the syndrome, flip the named bit and extract the payload.
    always_comb begin
        syndrome[0] = parity4(m[0], m[2], m[4], m[6]);
        syndrome[1] = parity4(m[1], m[2], m[5], m[6]);
        syndrome[2] = parity4(m[3], m[4], m[5], m[6]);
        m_fix_s     = m;
        if (syndrome != 3'd0) begin
            m_fix_s[syndrome - 3'd1] = ~m[syndrome - 3'd1];
            corr                     = 1'b1;
        end else begin
            corr                     = 1'b0;
        end
        d_corr = {m_fix_s[D3], m_fix_s[D2], m_fix_s[D1], m_fix_s[D0]};
    end

endmodule

// File: rtl/hamming_rx_serial.sv
// Serial receiver for Hamming(7,4) codewords framed by a start and a stop
// bit. The line is synchronized, the start bit is re-checked at its middle,
// and each subsequent bit is sampled one bit time later, i.e. mid-bit. A
// good stop bit registers the corrected payload and pulses valid; a low stop
// bit pulses frame_err and waits for the line to return high.
module hamming_rx_serial
    import hamming_rx_serial_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 1250
) (
    input  logic               clk,
    input  logic               rst_n,
    hamming_rx_serial_if.slave bus
);

    localparam int unsigned     CNT_W     = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);

    logic             rx_meta_r;
    logic             rx_sync_r;
    rx_state_e        state_r;
    rx_state_e        state_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic [2:0]       idx_r;
    logic [2:0]       idx_nxt_s;
    logic [6:0]       shift_r;
    logic [6:0]       shift_nxt_s;
    logic             good_s;
    logic             bad_s;
    logic [3:0]       dec_d_s;
    logic [2:0]       dec_syn_s;
    logic             dec_corr_s;
    logic             corr_s;
    logic [3:0]       d_out_r;
    logic             valid_r;
    logic             corr_r;
    logic             frame_err_r;

    hamming_syndrome_7_4 u_syndrome (
        .m        (shift_r),
        .syndrome (dec_syn_s),
        .d_corr   (dec_d_s),
        .corr     (dec_corr_s)
    );

    // A correction is reported only when the syndrome actually names a bit.
    assign corr_s = dec_corr_s & (dec_syn_s != 3'd0);

    // Next-state, counter, bit index and shift register logic.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r + CNT_ONE;
        idx_nxt_s   = idx_r;
        shift_nxt_s = shift_r;
        good_s      = 1'b0;
        bad_s       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                cnt_nxt_s = CNT_ZERO;
                if (!rx_sync_r) begin
                    state_nxt_s = ST_START;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (cnt_r == HALF_LAST) begin
                    cnt_nxt_s = CNT_ZERO;
                    if (!rx_sync_r) begin
                        state_nxt_s = ST_DATA;
                        idx_nxt_s   = 3'd0;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end else begin
                    state_nxt_s = ST_START;
                end
            end
            ST_DATA: begin
                if (cnt_r == BIT_LAST) begin
                    cnt_nxt_s   = CNT_ZERO;
                    shift_nxt_s = {rx_sync_r, shift_r[6:1]};
                    if (idx_r == 3'd6) begin
                        state_nxt_s = ST_STOP;
                    end else begin
                        idx_nxt_s = idx_r + 3'd1;
                    end
                end else begin
                    state_nxt_s = ST_DATA;
                end
            end
            ST_STOP: begin
                if (cnt_r == BIT_LAST) begin
                    cnt_nxt_s = CNT_ZERO;
                    if (rx_sync_r) begin
                        good_s      = 1'b1;
                        state_nxt_s = ST_IDLE;
                    end else begin
                        bad_s       = 1'b1;
                        state_nxt_s = ST_BREAK;
                    end
                end else begin
                    state_nxt_s = ST_STOP;
                end
            end
            ST_BREAK: begin
                cnt_nxt_s = CNT_ZERO;
                if (rx_sync_r) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_BREAK;
                end
            end
            default: begin
                cnt_nxt_s   = CNT_ZERO;
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Line synchronizer, FSM state, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_meta_r   <= 1'b1;
            rx_sync_r   <= 1'b1;
            state_r     <= ST_IDLE;
            cnt_r       <= CNT_ZERO;
            idx_r       <= 3'd0;
            shift_r     <= 7'd0;
            d_out_r     <= 4'd0;
            valid_r     <= 1'b0;
            corr_r      <= 1'b0;
            frame_err_r <= 1'b0;
        end else begin
            rx_meta_r   <= bus.rx;
            rx_sync_r   <= rx_meta_r;
            state_r     <= state_nxt_s;
            cnt_r       <= cnt_nxt_s;
            idx_r       <= idx_nxt_s;
            shift_r     <= shift_nxt_s;
            valid_r     <= good_s;
            corr_r      <= good_s & corr_s;
            frame_err_r <= bad_s;
            if (good_s) begin
                d_out_r <= dec_d_s;
            end
        end
    end

    assign bus.d_out     = d_out_r;
    assign bus.valid     = valid_r;
    assign bus.corr      = corr_r;
    assign bus.frame_err = frame_err_r;

endmodule

// File: tb/tb_hamming_rx_serial.sv
// Directed and randomized bench for hamming_rx_serial. Expected payloads
// come from encoding a nibble with the parity equations and optionally
// flipping one bit; a single error must always decode back to the nibble.
module tb_hamming_rx_serial;

    localparam int CPB = 4;

    logic clk;
    logic rst_n;

    hamming_rx_serial_if bus ();

    hamming_rx_serial #(.CLKS_PER_BIT(CPB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [4:0] obs_q[$];
    logic [4:0] exp_q[$];
    int         fe_cnt    = 0;
    int         both_cnt  = 0;
    int         leak_cnt  = 0;

    // Monitor: record every valid pulse and count frame errors/anomalies.
    always @(negedge clk) begin
        if (bus.valid === 1'b1) obs_q.push_back({bus.d_out, bus.corr});
        if (bus.frame_err === 1'b1) fe_cnt++;
        if (bus.valid === 1'b1 && bus.frame_err === 1'b1) both_cnt++;
        if (bus.valid !== 1'b1 && bus.corr !== 1'b0) leak_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] encode(input logic [3:0] d);
        logic p1, p2, p4;
        p1 = d[0] ^ d[1] ^ d[3];
        p2 = d[0] ^ d[2] ^ d[3];
        p4 = d[1] ^ d[2] ^ d[3];
        return {d[3], d[2], d[1], p4, d[0], p2, p1};
    endfunction

    // err = 0: clean, err = k (1..7): flip m[k-1]
    function automatic logic [6:0] corrupt(input logic [6:0] m, input int err);
        logic [6:0] r;
        r = m;
        if (err > 0) r[err-1] = ~r[err-1];
        return r;
    endfunction

    task automatic drive_bit(input logic b);
        bus.rx = b;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [6:0] m, input int stop_low_bits);
        drive_bit(1'b0);
        for (int i = 0; i < 7; i++) drive_bit(m[i]);
        for (int i = 0; i < stop_low_bits; i++) drive_bit(1'b0);
        drive_bit(1'b1);
    endtask

    task automatic idle(input int n);
        bus.rx = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] nib;
        logic [6:0] cw;
        int         err;
        int         fe_base;
        logic [3:0] prev_d;

        bus.rx = 1'b1;
        rst_n  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_d_out", bus.d_out, 4'd0);
        check("reset_valid", bus.valid, 1'b0);
        check("reset_corr", bus.corr, 1'b0);
        check("reset_frame_err", bus.frame_err, 1'b0);
        rst_n = 1'b1;
        idle(5);

        // Clean frame
        obs_q.delete();
        send_frame(7'b1010101, 0);
        idle(10);
        check("clean_count", obs_q.size(), 1);
        if (obs_q.size() > 0) check("clean_frame", obs_q[0], {4'b1011, 1'b0});

        // Single error at m[4]
        obs_q.delete();
        send_frame(7'b1000101, 0);
        idle(10);
        check("single_err_count", obs_q.size(), 1);
        if (obs_q.size() > 0) check("single_err", obs_q[0], {4'b1011, 1'b1});

        // Exhaustive sweep, back-to-back, random order of error patterns
        obs_q.delete();
        exp_q.delete();
        for (int n = 0; n < 16; n++) begin
            int off;
            off = int'($urandom_range(0, 7));
            for (int e = 0; e < 8; e++) begin
                nib = 4'(n);
                err = (e + off) % 8;
                send_frame(corrupt(encode(nib), err), 0);
                exp_q.push_back({nib, (err != 0) ? 1'b1 : 1'b0});
            end
        end
        idle(10);
        check("sweep_count", obs_q.size(), 128);
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < obs_q.size()) check("sweep_frame", obs_q[i], exp_q[i]);
        end
        prev_d = exp_q[exp_q.size()-1][4:1];

        // Stop bit held low for 3 bit times
        obs_q.delete();
        fe_base = fe_cnt;
        send_frame(encode(4'b0101), 3);
        idle(10);
        check("break_frame_err", fe_cnt - fe_base, 1);
        check("break_no_valid", obs_q.size(), 0);
        check("break_d_hold", bus.d_out, prev_d);
        send_frame(encode(4'b1100), 0);
        idle(10);
        check("after_break_count", obs_q.size(), 1);
        if (obs_q.size() > 0) check("after_break", obs_q[0], {4'b1100, 1'b0});

        // Glitch while idle
        obs_q.delete();
        fe_base = fe_cnt;
        bus.rx = 1'b0;
        @(posedge clk);
        #1;
        idle(20);
        check("glitch_no_valid", obs_q.size(), 0);
        check("glitch_no_fe", fe_cnt - fe_base, 0);
        send_frame(corrupt(encode(4'b0011), 1), 0);
        idle(10);
        check("after_glitch_count", obs_q.size(), 1);
        if (obs_q.size() > 0) check("after_glitch", obs_q[0], {4'b0011, 1'b1});

        // Reset pulse during m[3], then a clean frame for 0110
        obs_q.delete();
        fe_base = fe_cnt;
        cw = encode(4'b1111);
        drive_bit(1'b0);
        for (int i = 0; i < 3; i++) drive_bit(cw[i]);
        bus.rx = cw[3];
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("midreset_d_out", bus.d_out, 4'd0);
        idle(20);
        send_frame(encode(4'b0110), 0);
        idle(10);
        check("midreset_count", obs_q.size(), 1);
        if (obs_q.size() > 0) check("midreset_frame", obs_q[0], {4'b0110, 1'b0});
        check("midreset_no_fe", fe_cnt - fe_base, 0);

        // Random frames
        obs_q.delete();
        exp_q.delete();
        for (int k = 0; k < 20; k++) begin
            nib = 4'($urandom_range(0, 15));
            err = int'($urandom_range(0, 7));
            send_frame(corrupt(encode(nib), err), 0);
            exp_q.push_back({nib, (err != 0) ? 1'b1 : 1'b0});
        end
        idle(10);
        check("random_count", obs_q.size(), 20);
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < obs_q.size()) check("random_frame", obs_q[i], exp_q[i]);
        end

        check("valid_fe_overlap", both_cnt, 0);
        check("corr_without_valid", leak_cnt, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hamming_rx_serial.md
# hamming_rx_serial

Serial receiving end for Hamming(7,4) codewords sent over a single UART-style line. The block oversamples the asynchronous line and frames each codeword with a start bit and a stop bit. It corrects any single-bit error and presents the 4-bit payload with a one-cycle valid strobe. It sits after the serial Hamming transmitter/channel in the lab chain; its decoded nibble drives LEDs or downstream logic.

## Interface
- CLKS_PER_BIT, default 1250: clock cycles per serial bit (12 MHz / 9600 baud); legal range ≥ 4.
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- rx  input  1  asynchronous serial line; idles high.
- d_out  output  4  last corrected payload, held until the next good frame.
- valid  output  1  one-cycle pulse: a good frame was received and d_out was updated.
- corr  output  1  qualified by valid: syndrome was non-zero and one bit was flipped.
- frame_err  output  1  one-cycle pulse: stop bit was sampled low.

## Operation
- Frame: start bit (0), then m[0]..m[6] LSB first, then stop bit (1).
- Codeword layout (position 1..7 = m[0]..m[6]):
  - p1, p2, d0, p4, d1, d2, d3
  - p1 = d0^d1^d3, p2 = d0^d2^d3, p4 = d1^d2^d3.
- Syndrome s = {s4,s2,s1}:
  - s1 = m0^m2^m4^m6, s2 = m1^m2^m5^m6, s4 = m3^m4^m5^m6.
  - s ≠ 0: invert m[s-1]. d_out = {m6,m5,m4,m2} after correction.
- rx passes through a 2-FF synchronizer; rx_s denotes the synchronized value.
- FSM states and transitions:
  - IDLE: rx_s = 0 → START, baud counter cleared.
  - START: at count CLKS_PER_BIT/2 − 1 (mid start bit), rx_s = 0 → DATA, counter cleared, bit index 0. rx_s = 1 → IDLE (glitch rejected, no outputs).
  - DATA: every CLKS_PER_BIT cycles sample rx_s into m[idx] and increment idx. After m[6] is sampled → STOP.
  - STOP: after CLKS_PER_BIT cycles sample rx_s (mid stop bit).
    - rx_s = 1 → register decode result; valid = 1 next cycle; → IDLE.
    - rx_s = 0 → frame_err = 1 next cycle; d_out and corr unchanged; → BREAK.
  - BREAK: wait for rx_s = 1 → IDLE.
- Counter width is $clog2(CLKS_PER_BIT); it is cleared on every state change.
- A start edge arriving in the same cycle valid is pulsed is accepted, so back-to-back frames are received with no gap needed beyond the stop bit.
- Double-bit errors are miscorrected silently; this is inherent to Hamming(7,4) and must not be flagged.

## Timing
- Reset: state IDLE, d_out = 0, valid = 0, corr = 0, frame_err = 0, shift register = 0, counters = 0.
- Reset asserted mid-frame aborts the frame the next clock; no valid or frame_err pulse is produced for it.
- Latency: the line falling edge reaches rx_s 2 cycles later. The mid-stop sample occurs CLKS_PER_BIT/2 − 1 + 8·CLKS_PER_BIT cycles after rx_s falls. valid/frame_err follow 1 cycle after that sample.
- valid and frame_err are never high in the same cycle; each is high for exactly 1 cycle per frame.
- corr is meaningful only while valid = 1 and is driven 0 otherwise.

## Structure
- Shared package/header holds:
  - state encodings (IDLE, START, DATA, STOP, BREAK)
  - codeword bit-position constants (P1=0, P2=1, D0=2, P4=3, D1=4, D2=5, D3=6)
- Sub-module hamming_syndrome_7_4: combinational; input m[6:0], outputs syndrome[2:0], d_corr[3:0], corr. It is reusable by the bench as a reference model.
- Top holds the synchronizer, FSM, baud counter, bit index and shift register.

## Test plan
Run with CLKS_PER_BIT = 4.
- Clean frame: send codeword 7'b1010101 (d = 4'b1011) → one valid pulse, d_out = 4'b1011, corr = 0.
- Single error: send 7'b1000101 (m[4] flipped) → s = 5, d_out = 4'b1011, corr = 1.
- Exhaustive sweep: all 16 nibbles × 8 error patterns (none or one of m[0]..m[6]) back-to-back → 128 valid pulses, each with the correct d_out.
- Stop bit low: stop bit held at 0 for 3 bit times → frame_err pulse, no valid, d_out keeps the previous value. The next clean frame after the line goes high decodes normally.
- Glitch: rx low for 1 cycle while IDLE → no outputs, FSM back in IDLE.
- Reset mid-frame: assert rst_n = 0 for 1 cycle during m[3], then send a clean frame for d = 4'b0110 → only one valid pulse, d_out = 4'b0110.
